vr_udp_tx_arb: RTL

Shares the single UDP transmit path (one metadata handshake followed by a data stream) between NUM_SRC VR message engines: do-change, prepare, commit, start-view and similar. Each source presents one metadata word, then one or more data beats ending with last. The block grants the path round-robin and holds the grant from metadata acceptance through the last data beat. Packets from different sources never interleave. It sits between the per-message controllers and the UDP TX formatter.

---
 rtl/vr_tx_arb_pkg.sv | 17 +
 rtl/vr_rr_pick.sv | 30 +++
 rtl/vr_udp_tx_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vr_tx_arb_pkg.sv
// Shared types and default widths for the VR UDP transmit-path arbiter.
package vr_tx_arb_pkg;

  localparam int unsigned DEF_NUM_SRC = 4;
  localparam int unsigned DEF_META_W  = 96;
  localparam int unsigned DEF_DATA_W  = 512;
  localparam int unsigned DEF_PAD_W   = 6;
  localparam int unsigned DEF_IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    DATA = 2'd2,
    UND  = 'x
  } state_t;

endpackage

// File: rtl/vr_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with
// explicit wrap so non-power-of-two source counts never alias.
module vr_rr_pick
  import vr_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned IDX_W   = DEF_IDX_W
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!found && req[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/vr_udp_tx_arb.sv
// Round-robin arbiter sharing the UDP TX metadata+data path between VR
// message engines; the grant is held from metadata accept to the last beat.
module vr_udp_tx_arb
  import vr_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned META_W  = DEF_META_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned PAD_W   = DEF_PAD_W,
  parameter int unsigned IDX_W   = DEF_IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_meta_val,
  input  logic [NUM_SRC*META_W-1:0]  src_meta,
  output logic [NUM_SRC-1:0]         src_meta_rdy,
  input  logic [NUM_SRC-1:0]         src_data_val,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_SRC-1:0]         src_data_last,
  input  logic [NUM_SRC*PAD_W-1:0]   src_data_padbytes,
  output logic [NUM_SRC-1:0]         src_data_rdy,
  output logic                       dst_meta_val,
  output logic [META_W-1:0]          dst_meta,
  input  logic                       dst_meta_rdy,
  output logic                       dst_data_val,
  output logic [DATA_W-1:0]          dst_data,
  output logic                       dst_data_last,
  output logic [PAD_W-1:0]           dst_data_padbytes,
  input  logic                       dst_data_rdy,
  output logic                       busy,
  output logic [IDX_W-1:0]           grant_idx
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             data_done;

  logic [META_W-1:0] meta_arr [NUM_SRC];
  logic [DATA_W-1:0] data_arr [NUM_SRC];
  logic [PAD_W-1:0]  pad_arr  [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign meta_arr[i] = src_meta[i*META_W +: META_W];
    assign data_arr[i] = src_data[i*DATA_W +: DATA_W];
    assign pad_arr[i]  = src_data_padbytes[i*PAD_W +: PAD_W];
  end

  vr_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (src_meta_val),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign data_done = (state == DATA) && src_data_val[grant_idx] &&
                     dst_data_rdy && src_data_last[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = META;
      META:    if (src_meta_val[grant_idx] && dst_meta_rdy) state_nxt = DATA;
      DATA:    if (data_done) state_nxt = IDLE;
      default: state_nxt = UND;
    endcase
  end

  // Search restarts just past the source that last finished a packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      if (state == IDLE && pick_found) grant_idx <= pick_idx;
      if (data_done)
        rr_ptr <= (32'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_comb begin
    src_meta_rdy      = '0;
    src_data_rdy      = '0;
    dst_meta_val      = 1'b0;
    dst_meta          = '0;
    dst_data_val      = 1'b0;
    dst_data          = '0;
    dst_data_last     = 1'b0;
    dst_data_padbytes = '0;
    busy              = 1'b0;
    case (state)
      IDLE: ;
      META: begin
        busy                    = 1'b1;
        dst_meta_val            = src_meta_val[grant_idx];
        dst_meta                = meta_arr[grant_idx];
        src_meta_rdy[grant_idx] = dst_meta_rdy;
      end
      DATA: begin
        busy                    = 1'b1;
        dst_data_val            = src_data_val[grant_idx];
        dst_data                = data_arr[grant_idx];
        dst_data_last           = src_data_last[grant_idx];
        dst_data_padbytes       = pad_arr[grant_idx];
        src_data_rdy[grant_idx] = dst_data_rdy;
      end
      default: begin
        src_meta_rdy      = 'x;
        src_data_rdy      = 'x;
        dst_meta_val      = 1'bx;
        dst_meta          = 'x;
        dst_data_val      = 1'bx;
        dst_data          = 'x;
        dst_data_last     = 1'bx;
        dst_data_padbytes = 'x;
        busy              = 1'bx;
      end
    endcase
  end

endmodule
